sb_axil_ram_s: RTL

Synthesizable AXI-Lite subordinate backed by a word-addressed RAM with byte-strobe writes. It is the responder counterpart to the switchboard-driven AXI-Lite master in simulation benches, and serves as the default endpoint when exercising AXI-Lite traffic from Python. Write and read paths are independent; each handshake follows AXI-Lite rules, and responses are fully registered.

---
 rtl/sb_axil_ram_s.sv | 137 +++++++++++++
 1 files changed

// File: rtl/sb_axil_ram_s.sv
// AXI-Lite subordinate backed by a word-addressed RAM with byte-strobe writes.
// Write and read channels are independent; all responses come from registers.
module sb_axil_ram_s #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int STRB_WIDTH = DATA_WIDTH / 8,
    parameter int DEPTH_LOG2 = 8
) (
    input  logic                  clk,
    input  logic                  nreset,

    input  logic [ADDR_WIDTH-1:0] s_axil_awaddr,
    input  logic [2:0]            s_axil_awprot,
    input  logic                  s_axil_awvalid,
    output logic                  s_axil_awready,

    input  logic [DATA_WIDTH-1:0] s_axil_wdata,
    input  logic [STRB_WIDTH-1:0] s_axil_wstrb,
    input  logic                  s_axil_wvalid,
    output logic                  s_axil_wready,

    output logic [1:0]            s_axil_bresp,
    output logic                  s_axil_bvalid,
    input  logic                  s_axil_bready,

    input  logic [ADDR_WIDTH-1:0] s_axil_araddr,
    input  logic [2:0]            s_axil_arprot,
    input  logic                  s_axil_arvalid,
    output logic                  s_axil_arready,

    output logic [DATA_WIDTH-1:0] s_axil_rdata,
    output logic [1:0]            s_axil_rresp,
    output logic                  s_axil_rvalid,
    input  logic                  s_axil_rready
);

    localparam int ADDR_LSB = $clog2(STRB_WIDTH);
    localparam int DEPTH    = 1 << DEPTH_LOG2;
    localparam int TOP_LSB  = ADDR_LSB + DEPTH_LOG2;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Any address bit above the word index makes the access out of range.
    function automatic logic out_of_range(input logic [ADDR_WIDTH-1:0] addr);
        return (addr >> TOP_LSB) != '0;
    endfunction

    function automatic logic [DEPTH_LOG2-1:0] word_index(input logic [ADDR_WIDTH-1:0] addr);
        return addr[ADDR_LSB +: DEPTH_LOG2];
    endfunction

    logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

    logic                  aw_held;
    logic [ADDR_WIDTH-1:0] aw_addr;
    logic                  w_held;
    logic [DATA_WIDTH-1:0] w_data;
    logic [STRB_WIDTH-1:0] w_strb;
    logic                  commit;
    logic                  ar_fire;
    logic                  unused_ok;

    assign s_axil_awready = !aw_held;
    assign s_axil_wready  = !w_held;
    assign commit         = aw_held && w_held && (!s_axil_bvalid || s_axil_bready);

    assign s_axil_arready = !s_axil_rvalid || s_axil_rready;
    assign ar_fire        = s_axil_arvalid && s_axil_arready;

    assign unused_ok = ^{s_axil_awprot, s_axil_arprot, aw_addr, s_axil_araddr};

    // Capture AW and W independently; a held pair commits once the B slot is free.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            aw_held       <= 1'b0;
            aw_addr       <= '0;
            w_held        <= 1'b0;
            w_data        <= '0;
            w_strb        <= '0;
            s_axil_bvalid <= 1'b0;
            s_axil_bresp  <= RESP_OKAY;
        end else begin
            if (commit) begin
                aw_held       <= 1'b0;
                w_held        <= 1'b0;
                s_axil_bvalid <= 1'b1;
                s_axil_bresp  <= out_of_range(aw_addr) ? RESP_SLVERR : RESP_OKAY;
            end else if (s_axil_bready) begin
                s_axil_bvalid <= 1'b0;
            end

            if (s_axil_awvalid && !aw_held) begin
                aw_held <= 1'b1;
                aw_addr <= s_axil_awaddr;
            end

            if (s_axil_wvalid && !w_held) begin
                w_held <= 1'b1;
                w_data <= s_axil_wdata;
                w_strb <= s_axil_wstrb;
            end
        end
    end

    // RAM contents survive reset, so the array lives in its own unreset block.
    always_ff @(posedge clk) begin
        if (commit && !out_of_range(aw_addr)) begin
            for (int i = 0; i < STRB_WIDTH; i++) begin
                if (w_strb[i]) begin
                    mem[word_index(aw_addr)][i*8 +: 8] <= w_data[i*8 +: 8];
                end
            end
        end
    end

    // A read on the same edge as a commit to that word sees the old contents.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            s_axil_rvalid <= 1'b0;
            s_axil_rdata  <= '0;
            s_axil_rresp  <= RESP_OKAY;
        end else if (ar_fire) begin
            s_axil_rvalid <= 1'b1;
            if (out_of_range(s_axil_araddr)) begin
                s_axil_rdata <= '0;
                s_axil_rresp <= RESP_SLVERR;
            end else begin
                s_axil_rdata <= mem[word_index(s_axil_araddr)];
                s_axil_rresp <= RESP_OKAY;
            end
        end else if (s_axil_rready) begin
            s_axil_rvalid <= 1'b0;
        end
    end

endmodule
